tff_pattern_sequencer: RTL and testbench



---
 rtl/tff_seq_pkg.sv | 15 +
 rtl/moore_t.sv | 21 ++
 rtl/tff_pattern_sequencer.sv | 113 +++++++++++
 tb/tb_tff_pattern_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tff_seq_pkg.sv
// Shared types and defaults for the toggle-FSM pattern sequencer.
package tff_seq_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int CNT_W_DEF = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      SHIFT  = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/moore_t.sv
// Moore toggle FSM: z flips on every edge that samples x=1; synchronous reset clears z.
module moore_t (
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic z
);

   logic tog;

   always_ff @(posedge clk) begin
      if (reset) begin
         tog <= 1'b0;
      end else if (x) begin
         tog <= ~tog;
      end
   end

   assign z = tog;

endmodule

// File: rtl/tff_pattern_sequencer.sv
// Clears a toggle FSM, shifts a programmed pattern into its x input LSB first,
// then compares its z output against the parity of the applied ones.
//
// state  | meaning
// IDLE   | waiting for start; captures pattern and clamped length on accept
// INIT   | one-cycle clear pulse to the toggle FSM, result fields cleared
// SHIFT  | one pattern bit per cycle on x_out, ones counted
// SETTLE | z_in now reflects every applied toggle; result registered
// DONE   | one-cycle completion pulse
module tff_pattern_sequencer
   import tff_seq_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] len,
   input  logic             z_in,
   output logic             x_out,
   output logic             fsm_rst,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] ones_cnt,
   output logic             z_final,
   output logic             mismatch
);

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(PAT_W);

   state_e           state;
   state_e           state_nxt;
   logic [PAT_W-1:0] shreg;
   logic [CNT_W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = INIT;
         INIT:    state_nxt = (remaining != '0) ? SHIFT : SETTLE;
         SHIFT:   if (remaining == CNT_W'(1)) state_nxt = SETTLE;
         SETTLE:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg     <= '0;
         remaining <= '0;
         ones_cnt  <= '0;
         z_final   <= 1'b0;
         mismatch  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg     <= pattern;
                  remaining <= (len > LEN_MAX) ? LEN_MAX : len;
               end
            end
            INIT: begin
               ones_cnt <= '0;
               z_final  <= 1'b0;
               mismatch <= 1'b0;
            end
            SHIFT: begin
               shreg     <= shreg >> 1;
               remaining <= remaining - CNT_W'(1);
               if (shreg[0]) ones_cnt <= ones_cnt + CNT_W'(1);
            end
            SETTLE: begin
               z_final  <= z_in;
               mismatch <= z_in ^ ones_cnt[0];
            end
            default: ;
         endcase
      end
   end

   // Pure state decode keeps every control output free of input-to-output paths.
   always_comb begin
      x_out   = 1'b0;
      fsm_rst = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         INIT: begin
            fsm_rst = 1'b1;
            busy    = 1'b1;
         end
         SHIFT: begin
            x_out = shreg[0];
            busy  = 1'b1;
         end
         SETTLE:  busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tff_pattern_sequencer.sv
// Randomized and directed bench for the sequencer wrapped around a moore_t instance.
module tb_tff_pattern_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] len;
   logic       z_in;
   logic       x_out;
   logic       fsm_rst;
   logic       busy;
   logic       done;
   logic [3:0] ones_cnt;
   logic       z_final;
   logic       mismatch;
   logic       z_m;
   logic       force_z;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tff_pattern_sequencer #(.PAT_W(8), .CNT_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pattern  (pattern),
      .len      (len),
      .z_in     (z_in),
      .x_out    (x_out),
      .fsm_rst  (fsm_rst),
      .busy     (busy),
      .done     (done),
      .ones_cnt (ones_cnt),
      .z_final  (z_final),
      .mismatch (mismatch)
   );

   moore_t u_tff (
      .clk   (clk),
      .reset (reset | fsm_rst),
      .x     (x_out),
      .z     (z_m)
   );

   assign z_in = force_z ? 1'b0 : z_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("idle_timeout", 1, 0);
   endtask

   // Reference: n = min(len,8) bits of pattern LSB first, framed by INIT before and
   // SETTLE/DONE after; the toggle FSM ends at the parity of the applied ones.
   task automatic run_seq(input logic [7:0] pat, input logic [3:0] ln, input bit frc, input bit hold);
      int n;
      int ones;
      logic exp_z;
      logic exp_x;
      n    = (int'(ln) > 8) ? 8 : int'(ln);
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(pat[i]);
      exp_z = frc ? 1'b0 : ones[0];
      wait_idle();
      force_z = frc;
      pattern = pat;
      len     = ln;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      for (int k = 0; k <= n + 2; k++) begin
         if (k > 0) @(negedge clk);
         exp_x = (k >= 1 && k <= n) ? pat[k-1] : 1'b0;
         check($sformatf("x_out[k=%0d]", k), x_out, exp_x);
         check($sformatf("fsm_rst[k=%0d]", k), fsm_rst, (k == 0));
         check($sformatf("busy[k=%0d]", k), busy, (k <= n + 1));
         check($sformatf("done[k=%0d]", k), done, (k == n + 2));
      end
      check("ones_cnt", ones_cnt, ones);
      check("z_final", z_final, exp_z);
      check("mismatch", mismatch, exp_z ^ ones[0]);
      if (hold) begin
         @(negedge clk);
         check("hold_idle_busy", busy, 0);
         check("hold_idle_rst", fsm_rst, 0);
         @(negedge clk);
         check("hold_reinit", fsm_rst, 1);
         start = 1'b0;
         wait_idle();
         check("hold_rerun_ones", ones_cnt, ones);
         check("hold_rerun_z", z_final, exp_z);
      end else begin
         @(negedge clk);
         check("held_ones", ones_cnt, ones);
         check("held_mismatch", mismatch, exp_z ^ ones[0]);
      end
      force_z = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_x"}, x_out, 0);
      check({tag, "_rst"}, fsm_rst, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ones"}, ones_cnt, 0);
      check({tag, "_zf"}, z_final, 0);
      check({tag, "_mm"}, mismatch, 0);
   endtask

   initial begin
      int seen_done;
      reset   = 1'b1;
      start   = 1'b0;
      pattern = '0;
      len     = '0;
      force_z = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outs("reset");
      reset = 1'b0;

      run_seq(8'h2D, 4'd6, 1'b0, 1'b0);
      run_seq(8'hFF, 4'd3, 1'b0, 1'b0);
      run_seq(8'h00, 4'd8, 1'b0, 1'b0);
      run_seq(8'hA5, 4'd0, 1'b0, 1'b0);
      run_seq(8'h01, 4'd12, 1'b0, 1'b0);
      run_seq(8'h01, 4'd1, 1'b1, 1'b0);
      run_seq(8'h6B, 4'd4, 1'b0, 1'b1);

      // Reset on the third SHIFT cycle aborts the run silently.
      wait_idle();
      pattern = 8'hFF;
      len     = 4'd8;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_abort_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outs("abort");
      reset = 1'b0;
      seen_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      check("abort_no_done", seen_done, 0);

      for (int r = 0; r < 30; r++) begin
         run_seq(8'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
